// File: rtl/mul_div_seq_pkg.sv
// Shared encodings and timing constants for the sequential signed multiply/divide unit.
package mul_div_seq_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int ITERS    = 32;
  localparam int MUL_LAT  = 33;
  localparam int DIV_LAT  = 37;
  localparam int DIV0_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_IT = 3'd1,
    S_NEG_A  = 3'd2,
    S_NEG_B  = 3'd3,
    S_DIV_IT = 3'd4,
    S_FIX_Q  = 3'd5,
    S_FIX_R  = 3'd6,
    S_FIN    = 3'd7
  } state_t;

endpackage

// File: rtl/mul_div_seq_add.sv
// Ripple-carry adder shared by every add, subtract and negate step of mul_div_seq.
module add_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] c;
  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum_o[i] = x_i[i] ^ y_i[i] ^ c[i];
    assign c[i+1]   = (x_i[i] & y_i[i]) | (c[i] & (x_i[i] ^ y_i[i]));
  end

  assign cout_o = c[W];

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle signed MUL (radix-2 Booth) / DIV (restoring on magnitudes) around one adder.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int N_ITERS = ITERS
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, q_q, m_q, hi_q, lo_q;
  logic             qm1_q, a_sgn_q, b_sgn_q, dz_q, dz_o_q, done_q;
  logic [4:0]       cnt_q;

  logic [WIDTH-1:0] ax, ay, sum, rp;
  logic             acin, cout, sign_ext, last_it;

  assign rp       = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign last_it  = (cnt_q == 5'(N_ITERS - 1));
  // Full 33-bit sign of the Booth add; needed when M = most-negative value.
  assign sign_ext = ax[WIDTH-1] ^ ay[WIDTH-1] ^ cout;

  add_32 #(.W(WIDTH)) u_add (
    .x_i   (ax),
    .y_i   (ay),
    .cin_i (acin),
    .sum_o (sum),
    .cout_o(cout)
  );

  always_comb begin
    ax   = '0;
    ay   = '0;
    acin = 1'b0;
    case (state_q)
      S_MUL_IT: begin
        ax = acc_q;
        case ({q_q[0], qm1_q})
          2'b01:   ay = m_q;
          2'b10:   begin ay = ~m_q; acin = 1'b1; end
          default: ;
        endcase
      end
      S_NEG_A:  begin ax = ~q_q;   acin = 1'b1; end
      S_NEG_B:  begin ax = ~m_q;   acin = 1'b1; end
      S_DIV_IT: begin ax = rp; ay = ~m_q; acin = 1'b1; end
      S_FIX_Q:  begin ax = ~q_q;   acin = 1'b1; end
      S_FIX_R:  begin ax = ~acc_q; acin = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (op == OP_MUL) ? S_MUL_IT :
                                     (B == '0)      ? S_FIN    : S_NEG_A;
      S_MUL_IT: if (last_it) state_d = S_FIN;
      S_NEG_A:  state_d = S_NEG_B;
      S_NEG_B:  state_d = S_DIV_IT;
      S_DIV_IT: if (last_it) state_d = S_FIX_Q;
      S_FIX_Q:  state_d = S_FIX_R;
      S_FIX_R:  state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qm1_q   <= 1'b0;
      a_sgn_q <= 1'b0;
      b_sgn_q <= 1'b0;
      dz_q    <= 1'b0;
      dz_o_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIN);
      case (state_q)
        S_IDLE: if (start) begin
          a_sgn_q <= A[WIDTH-1];
          b_sgn_q <= B[WIDTH-1];
          dz_q    <= (op == OP_DIV) && (B == '0);
          dz_o_q  <= 1'b0;
          acc_q   <= '0;
          qm1_q   <= 1'b0;
          cnt_q   <= '0;
          m_q     <= (op == OP_MUL) ? A : B;
          q_q     <= (op == OP_MUL) ? B : A;
        end
        S_MUL_IT: begin
          acc_q <= {sign_ext, sum[WIDTH-1:1]};
          q_q   <= {sum[0], q_q[WIDTH-1:1]};
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 5'd1;
        end
        S_NEG_A: if (a_sgn_q) q_q <= sum;
        S_NEG_B: if (b_sgn_q) m_q <= sum;
        S_DIV_IT: begin
          acc_q <= cout ? sum : rp;
          q_q   <= {q_q[WIDTH-2:0], cout};
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX_Q: if (a_sgn_q ^ b_sgn_q) q_q <= sum;
        S_FIX_R: if (a_sgn_q) acc_q <= sum;
        S_FIN: begin
          // Divide-by-zero skips the datapath; q_q still holds the raw dividend.
          hi_q   <= dz_q ? q_q : acc_q;
          lo_q   <= dz_q ? '1  : q_q;
          dz_o_q <= dz_q;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign HI          = hi_q;
  assign LO          = lo_q;
  assign div_by_zero = dz_o_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq: latency, HI/LO, flag, busy and done-pulse checks.
module tb_mul_div_seq;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  mul_div_seq dut (
    .clock      (clock),
    .clear_n    (clear_n),
    .start      (start),
    .op         (op),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .HI         (HI),
    .LO         (LO),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit opv, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sb64, p;
    logic signed [31:0] a32, b32;
    sa = $signed(a);
    sb64 = $signed(b);
    a32 = $signed(a);
    b32 = $signed(b);
    e.dz = 1'b0;
    if (!opv) begin
      p = sa * sb64;
      e.hi = p[63:32];
      e.lo = p[31:0];
      e.lat = 33;
    end else if (b == 32'h0) begin
      e.hi = a;
      e.lo = 32'hFFFF_FFFF;
      e.dz = 1'b1;
      e.lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.hi = 32'h0;
      e.lo = 32'h8000_0000;
      e.lat = 37;
    end else begin
      e.lo = 32'(a32 / b32);
      e.hi = 32'(a32 % b32);
      e.lat = 37;
    end
    return e;
  endfunction

  task automatic run_op(input bit opv, input logic [31:0] a, input logic [31:0] b, input bit inject);
    exp_t e;
    int   n;
    int   extra;
    bit   got;
    @(negedge clock);
    start = 1'b1; op = opv; A = a; B = b;
    sb.push_back(model(opv, a, b));
    @(posedge clock); #1;
    start = 1'b0; op = ~opv; A = $urandom; B = $urandom;
    chk("busy_after_accept", busy, 1);
    got = 0;
    n = 1;
    while (n <= 60) begin
      @(posedge clock); #1;
      if (done) begin got = 1; break; end
      if (!busy) chk("busy_midop", busy, 1);
      if (inject && n == 10) begin start = 1'b1; op = 1'b0; A = 32'd11; B = 32'd13; end
      if (inject && n == 11) start = 1'b0;
      n++;
    end
    e = sb.pop_front();
    if (!got) chk("done_timeout", 0, 1);
    chk("latency", n, e.lat);
    chk("HI", HI, e.hi);
    chk("LO", LO, e.lo);
    chk("div_by_zero", div_by_zero, e.dz);
    chk("busy_at_done", busy, 0);
    @(posedge clock); #1;
    chk("done_one_cycle", done, 0);
    chk("HI_hold", HI, e.hi);
    if (inject) begin
      extra = 0;
      repeat (40) begin
        @(posedge clock); #1;
        if (done) extra++;
      end
      chk("ignored_start_no_done", extra, 0);
      chk("ignored_start_busy", busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_HI", HI, 0);
    chk("rst_LO", LO, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clock);
    clear_n = 1'b1;

    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(1'b1, 32'd5, 32'd0, 0);
    run_op(1'b0, 32'h1234_5678, 32'h8765_4321, 1);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, 0);

    // Abort a DIV mid-flight with an asynchronous clear.
    @(negedge clock);
    start = 1'b1; op = 1'b1; A = 32'd1000; B = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    clear_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_HI", HI, 0);
    chk("abort_LO", LO, 0);
    @(negedge clock);
    clear_n = 1'b1;

    run_op(1'b0, 32'd6, 32'd6, 0);

    for (int i = 0; i < 12; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : $urandom_range(0, 40) - 20);
      run_op(i[0], ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
